// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit operands resolved CHUNK bits per stage,
// valid/ready on both sides with a single global advance enable.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int MSB    = WIDTH - 1;

  // Per-stage registers: operands (a, b_eff), partial sum, carry, valid.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic             src_v [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];
  logic [CHUNK:0]   part  [STAGES];

  logic adv;

  assign out_valid = v_q[STAGES-1];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  // Stage 0 sees the prepared port operands; later stages see their predecessor.
  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub ? ~cin : cin;
    src_s[0] = '0;
    src_v[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
      src_v[k] = v_q[k-1];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      part[k]  = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
               + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, src_c[k]};
      nxt_s[k] = src_s[k];
      nxt_s[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      nxt_c[k] = part[k][CHUNK];
    end
  end

  // Data only loads behind a valid beat, so outputs hold their last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= src_v[k];
        if (src_v[k]) begin
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
          s_q[k] <= nxt_s[k];
          c_q[k] <= nxt_c[k];
        end
      end
    end
  end

  assign sum  = s_q[STAGES-1];
  assign cout = c_q[STAGES-1];
  assign ovf  = (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB]) &&
                (s_q[STAGES-1][MSB] != a_q[STAGES-1][MSB]);

endmodule
